fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Multi-cycle instruction fetch stage that sits directly upstream of instruction decode in the multi-cycle RV32I core.
- Owns the program counter (pc_cur) and the PC of the instruction in flight (pc_old), which the AUIPC/JAL/branch datapath consumes as ALU source A.
- Issues one word read per fetch over a valid/ready request channel and latches the returned word into the instruction register.
- Driven by control_fsm: a fetch_start pulse in FETCH, and pc_write for jumps and branches.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, value loaded into pc_cur on reset.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- fetch_start  in  1  one-cycle request from control_fsm to begin a fetch.
- pc_write  in  1  load pc_cur from pc_next (jump, branch or redirect).
- pc_next  in  XLEN  new PC value.
- mem_req_valid  out  1  read request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  XLEN  word address (equals pc_cur).
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_data  in  XLEN  read data.
- instr  out  XLEN  instruction register.
- instr_valid  out  1  one-cycle pulse: instr, pc_old and pc_cur have just updated.
- pc_cur  out  XLEN  current PC (the next PC to fetch).
- pc_old  out  XLEN  PC of the instruction held in instr.
- busy  out  1  high in REQ and WAIT.
- fetch_fault  out  1  one-cycle pulse: fetch attempted at a misaligned PC.

Behaviour:
- Reset, when reset==0 at posedge:
  - pc_cur=RESET_PC, pc_old=0, instr=32'h0000_0013 (NOP).
  - instr_valid=0, mem_req_valid=0, busy=0, fetch_fault=0.
  - state=IDLE, kill=0.
  - Reset applies in any state. A response arriving after a mid-fetch reset is ignored because IDLE ignores mem_rsp_valid.
- State machine: IDLE, REQ, WAIT.
- IDLE:
  - If fetch_start and pc_cur[1:0]!=0: fetch_fault=1 for the next cycle; stay IDLE; no memory request.
  - If fetch_start and pc_cur is aligned: go to REQ.
- REQ:
  - mem_req_valid=1, mem_addr=pc_cur.
  - Once asserted, valid stays high until a cycle with mem_req_ready=1.
  - On that cycle go to WAIT.
- WAIT:
  - Waits for mem_rsp_valid. The earliest response is the cycle after acceptance.
  - On response, with kill=0: instr<=mem_rsp_data, pc_old<=pc_cur, pc_cur<=pc_cur+4; instr_valid=1 for the next cycle; go to IDLE.
- Latency: fetch_start at cycle 0 -> mem_req_valid at cycle 1. With ready at cycle 1 and rsp at cycle 2, instr_valid is high at cycle 3.
- PC arithmetic: modulo 2^XLEN, so 32'hFFFF_FFFC+4 = 32'h0000_0000. No carry-out.
- pc_write outside a fetch (IDLE): pc_cur<=pc_next next cycle. pc_old and instr are unchanged.
- pc_write while in REQ or WAIT:
  - pc_cur<=pc_next and kill<=1.
  - The outstanding request still completes its handshake, so mem_req_valid is not dropped.
  - The response is discarded: no instr_valid, no +4, instr unchanged. Then return to IDLE with kill cleared.
- pc_write in the same cycle as mem_rsp_valid: pc_write wins. The response is dropped and pc_cur=pc_next (not pc_next+4).
- fetch_start while busy: ignored, with no queueing.
- fetch_start and pc_write in the same IDLE cycle: pc_cur is loaded first, and alignment is checked on pc_next.
- Alignment is checked only at fetch_start. A misaligned pc_next is accepted into pc_cur and faults on the next fetch_start.
- Outputs instr, pc_old and pc_cur are registered and hold their value between fetches.

Decomposition:
- Shared package (riscv_pkg), holding:
  - fetch_state_t enum {IDLE, REQ, WAIT};
  - constant NOP_INSTR = 32'h0000_0013;
  - constant INSTR_BYTES = 4;
  - XLEN default.
- The pc_cur/pc_old register pair with its next-PC mux is a natural sub-module: pc_unit. The FSM and instruction register stay in fetch_unit.

Test Plan:
- Reset behaviour: hold reset=0 for 2 cycles, then release with RESET_PC=0. Require pc_cur=0, instr=32'h13 and mem_req_valid=0. Then pulse fetch_start with memory word0=32'h00014097. Require mem_addr=0, then instr=32'h00014097, pc_old=0, pc_cur=4 and an instr_valid pulse at cycle 3.
- Back-pressure: hold mem_req_ready=0 for 3 cycles. Require mem_req_valid and mem_addr=4 stable throughout. Then ready=1 and rsp=32'h000c8117 one cycle later. Require pc_old=4, pc_cur=8.
- Redirect mid-fetch: pc_write=1 with pc_next=32'h40 during WAIT, and the response 32'hdeadbeef arriving the same cycle. Require no instr_valid, instr unchanged, pc_cur=32'h40. The next fetch reads address 32'h40.
- Misaligned fetch: pc_write with pc_next=32'h42, then fetch_start. Require a fetch_fault pulse, mem_req_valid staying 0, and pc_cur staying 32'h42.
- Wrap-around: pc_write with pc_next=32'hFFFF_FFFC, then fetch with rsp 32'h003ff197. Require pc_old=32'hFFFF_FFFC and pc_cur=0.
- Reset mid-operation: assert reset=0 during WAIT, then deliver mem_rsp_valid the cycle after release. Require state IDLE, instr=32'h13, pc_cur=RESET_PC and no instr_valid.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the multi-cycle RV32I core: datapath width, fetch FSM
// state encoding and architectural constants used by the fetch stage.
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int INSTR_BYTES  = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    // Instructions are word aligned; only the two low PC bits matter.
    function automatic logic is_word_aligned(input logic [1:0] pc_lsb);
        return (pc_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel: a valid/ready request carrying the word
// address, followed by a response strobe with the read data.
interface fetch_unit_if
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_addr;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;

    modport master (
        output mem_req_valid,
        output mem_addr,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_addr,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_data
    );

endinterface

// File: rtl/pc_unit.sv
// Program counter pair: pc_cur (next PC to fetch) and pc_old (PC of the
// instruction in the instruction register), with the next-PC selection mux.
module pc_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_write,
    input  logic [XLEN-1:0] pc_next,
    input  logic            advance,
    output logic [XLEN-1:0] pc_cur,
    output logic [XLEN-1:0] pc_old
);

    logic [XLEN-1:0] pc_cur_reg;
    logic [XLEN-1:0] pc_cur_next;
    logic [XLEN-1:0] pc_old_reg;
    logic [XLEN-1:0] pc_old_next;

    // A redirect always beats a completing fetch; the increment wraps mod 2^XLEN.
    always_comb begin
        pc_cur_next = pc_cur_reg;
        pc_old_next = pc_old_reg;
        if (pc_write) begin
            pc_cur_next = pc_next;
        end else if (advance) begin
            pc_old_next = pc_cur_reg;
            pc_cur_next = pc_cur_reg + XLEN'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_cur_reg <= RESET_PC;
            pc_old_reg <= '0;
        end else begin
            pc_cur_reg <= pc_cur_next;
            pc_old_reg <= pc_old_next;
        end
    end

    assign pc_cur = pc_cur_reg;
    assign pc_old = pc_old_reg;

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle instruction fetch stage: issues one word read per fetch_start,
// latches the returned word into the instruction register and advances the PC.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_start,
    input  logic             pc_write,
    input  logic [XLEN-1:0]  pc_next,
    fetch_unit_if.master     mem,
    output logic [XLEN-1:0]  instr,
    output logic             instr_valid,
    output logic [XLEN-1:0]  pc_cur,
    output logic [XLEN-1:0]  pc_old,
    output logic             busy,
    output logic             fetch_fault
);

    fetch_state_t    state_reg;
    logic            kill_reg;
    logic [XLEN-1:0] instr_reg;
    logic            instr_valid_reg;
    logic            req_valid_reg;
    logic [XLEN-1:0] addr_reg;
    logic            busy_reg;
    logic            fault_reg;

    logic            advance;
    logic [XLEN-1:0] launch_pc;

    // A fetch started together with pc_write targets the new PC.
    assign launch_pc = pc_write ? pc_next : pc_cur;

    // The response only retires an instruction when no redirect is pending or arriving.
    assign advance = (state_reg == WAIT) && mem.mem_rsp_valid && !kill_reg && !pc_write;

    pc_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk      (clk),
        .reset    (reset),
        .pc_write (pc_write),
        .pc_next  (pc_next),
        .advance  (advance),
        .pc_cur   (pc_cur),
        .pc_old   (pc_old)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= IDLE;
            kill_reg        <= 1'b0;
            instr_reg       <= XLEN'(NOP_INSTR);
            instr_valid_reg <= 1'b0;
            req_valid_reg   <= 1'b0;
            addr_reg        <= RESET_PC;
            busy_reg        <= 1'b0;
            fault_reg       <= 1'b0;
        end else begin
            instr_valid_reg <= 1'b0;
            fault_reg       <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (fetch_start) begin
                        if (!is_word_aligned(launch_pc[1:0])) begin
                            fault_reg <= 1'b1;
                        end else begin
                            state_reg     <= REQ;
                            req_valid_reg <= 1'b1;
                            busy_reg      <= 1'b1;
                            addr_reg      <= launch_pc;
                        end
                    end
                end
                REQ: begin
                    // The address is held in addr_reg so a redirect cannot
                    // disturb a request that is still waiting for ready.
                    if (pc_write) begin
                        kill_reg <= 1'b1;
                    end
                    if (mem.mem_req_ready) begin
                        state_reg     <= WAIT;
                        req_valid_reg <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem.mem_rsp_valid) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        kill_reg  <= 1'b0;
                        if (advance) begin
                            instr_reg       <= mem.mem_rsp_data;
                            instr_valid_reg <= 1'b1;
                        end
                    end else if (pc_write) begin
                        kill_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    req_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    kill_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_req_valid = req_valid_reg;
    assign mem.mem_addr      = addr_reg;
    assign instr             = instr_reg;
    assign instr_valid       = instr_valid_reg;
    assign busy              = busy_reg;
    assign fetch_fault       = fault_reg;

endmodule
